sequenciador_oposicao: RTL and testbench

SEQUENCIADOR_OPOSICAO -- requirements
Module: sequenciador_oposicao

---
 rtl/sequenciador_oposicao.sv | 110 +++++++++++
 tb/tb_sequenciador_oposicao.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sequenciador_oposicao.sv
// Element-serial matrix negation sequencer: latches a source matrix and op,
// then writes one result element per clock through a single shared unit.

module unidade_negacao #(
    parameter int ELEM_W = 8
) (
    input  logic [1:0]        op,
    input  logic [ELEM_W-1:0] a,
    output logic [ELEM_W-1:0] y
);
    localparam logic [ELEM_W-1:0] MIN_NEG = {1'b1, {(ELEM_W-1){1'b0}}};
    localparam logic [ELEM_W-1:0] MAX_POS = {1'b0, {(ELEM_W-1){1'b1}}};

    logic [ELEM_W-1:0] neg;
    assign neg = ~a + 1'b1;

    always_comb begin
        y = '0;
        case (op)
            2'b00:   y = neg;
            // only the most negative value overflows on negation
            2'b01:   y = (a == MIN_NEG) ? MAX_POS : neg;
            2'b10:   y = a;
            default: y = '0;
        endcase
    end
endmodule

module sequenciador_oposicao #(
    parameter int N_ELEM = 25,
    parameter int ELEM_W = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [1:0]                 op,
    input  logic [N_ELEM*ELEM_W-1:0]   matriz_A,
    output logic [N_ELEM*ELEM_W-1:0]   resultado,
    output logic                       busy,
    output logic                       done,
    output logic [4:0]                 elem_idx
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} estado_t;

    localparam logic [4:0] ULTIMO = 5'(N_ELEM - 1);

    estado_t                   estado;
    logic [N_ELEM*ELEM_W-1:0]  a_lat;
    logic [1:0]                op_lat;
    logic [ELEM_W-1:0]         elem_sel;
    logic [ELEM_W-1:0]         elem_res;

    assign elem_sel = a_lat[elem_idx*ELEM_W +: ELEM_W];

    unidade_negacao #(.ELEM_W(ELEM_W)) u_neg (
        .op (op_lat),
        .a  (elem_sel),
        .y  (elem_res)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado    <= IDLE;
            a_lat     <= '0;
            op_lat    <= '0;
            resultado <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            elem_idx  <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_lat     <= matriz_A;
                        op_lat    <= op;
                        resultado <= '0;
                        elem_idx  <= '0;
                        busy      <= 1'b1;
                        estado    <= RUN;
                    end
                end
                RUN: begin
                    // abort wins over the write scheduled for this edge
                    if (abort) begin
                        busy     <= 1'b0;
                        elem_idx <= '0;
                        estado   <= IDLE;
                    end else begin
                        resultado[elem_idx*ELEM_W +: ELEM_W] <= elem_res;
                        if (elem_idx == ULTIMO) begin
                            busy     <= 1'b0;
                            done     <= 1'b1;
                            elem_idx <= '0;
                            estado   <= DONE;
                        end else begin
                            elem_idx <= elem_idx + 5'd1;
                        end
                    end
                end
                DONE: begin
                    done   <= 1'b0;
                    estado <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sequenciador_oposicao.sv
// Randomized bench for sequenciador_oposicao: a timeline model of the run is
// compared against the outputs every cycle, plus literal result checks.

module tb_sequenciador_oposicao;
    localparam int N  = 25;
    localparam int W  = 8;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [VW-1:0] matriz_A = '0;
    logic [VW-1:0] resultado;
    logic          busy, done;
    logic [4:0]    elem_idx;

    int tests = 0;
    int fails = 0;

    sequenciador_oposicao #(.N_ELEM(N), .ELEM_W(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .op        (op),
        .matriz_A  (matriz_A),
        .resultado (resultado),
        .busy      (busy),
        .done      (done),
        .elem_idx  (elem_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] f(logic [1:0] o, logic [7:0] a);
        int x;
        x = int'($signed(a));
        case (o)
            2'b00:   return 8'(-x);
            2'b01:   return (x == -128) ? 8'h7F : 8'(-x);
            2'b10:   return a;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [VW-1:0] rnd_mat();
        logic [VW-1:0] m;
        for (int i = 0; i < N; i++) m[i*W +: W] = 8'($urandom);
        return m;
    endfunction

    // Model: m_pos = -1 idle, 0..N-1 = element written on next edge, N = done cycle
    int            m_pos = -1;
    logic [VW-1:0] m_lat = '0;
    logic [VW-1:0] m_res = '0;
    logic [1:0]    m_op = 2'b00;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_pos = -1; m_lat = '0; m_res = '0; m_op = 2'b00;
        end else if (m_pos == N) begin
            m_pos = -1;
        end else if (m_pos >= 0) begin
            if (abort) m_pos = -1;
            else begin
                m_res[m_pos*W +: W] = f(m_op, m_lat[m_pos*W +: W]);
                m_pos++;
            end
        end else if (start) begin
            m_lat = matriz_A; m_op = op; m_res = '0; m_pos = 0;
        end
    end

    task automatic chk(string nm, logic [VW-1:0] act, logic [VW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        logic       run;
        logic [4:0] ei;
        run = (m_pos >= 0) && (m_pos < N);
        ei  = run ? 5'(m_pos) : 5'd0;
        chk("cyc_resultado", resultado, m_res);
        chk("cyc_busy", VW'(busy), VW'(run));
        chk("cyc_done", VW'(done), VW'(m_pos == N));
        chk("cyc_elem_idx", VW'(elem_idx), VW'(ei));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [VW-1:0] m,
                          output int lat, output int bcnt);
        matriz_A = m; op = o; start = 1'b1;
        tick();
        start = 1'b0; lat = 0; bcnt = 0;
        while (!done && lat < 40) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
    endtask

    task automatic wait_idx(input int k);
        int n;
        n = 0;
        while (elem_idx != 5'(k) && n < 60) begin tick(); n++; end
        chk("wait_idx", VW'(elem_idx), VW'(k));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int            lat, bcnt, dcnt, n;
        logic [VW-1:0] m0, expv;
        logic [1:0]    o0;
        logic [7:0]    pat [5];
        logic [7:0]    e00 [5];
        logic [7:0]    e01 [5];
        int            done_q[$], rise_q[$];
        logic          pb, pd, dbl;

        pat = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01};
        e00 = '{8'h80, 8'h81, 8'h00, 8'h01, 8'hFF};
        e01 = '{8'h7F, 8'h81, 8'h00, 8'h01, 8'hFF};

        // reset state
        tick(); tick();
        chk("rst_resultado", resultado, '0);
        chk("rst_busy", VW'(busy), '0);
        chk("rst_done", VW'(done), '0);
        chk("rst_idx", VW'(elem_idx), '0);
        reset = 1'b1;

        // wrap negation of all 5s
        run_op(2'b00, {N{8'h05}}, lat, bcnt);
        chk("wrap_latency", VW'(lat), VW'(25));
        chk("wrap_busy_cycles", VW'(bcnt), VW'(25));
        chk("wrap_result", resultado, {N{8'hFB}});
        tick();

        // boundary values, wrap then saturating
        for (int i = 0; i < N; i++) m0[i*W +: W] = pat[i % 5];
        run_op(2'b00, m0, lat, bcnt);
        for (int i = 0; i < N; i++) expv[i*W +: W] = e00[i % 5];
        chk("bound_wrap", resultado, expv);
        tick();
        run_op(2'b01, m0, lat, bcnt);
        for (int i = 0; i < N; i++) expv[i*W +: W] = e01[i % 5];
        chk("bound_sat", resultado, expv);
        tick();

        // input stability with a mid-run start
        m0 = rnd_mat(); o0 = 2'($urandom);
        matriz_A = m0; op = o0; start = 1'b1;
        tick();
        dcnt = 0;
        for (int i = 0; i < 32; i++) begin
            matriz_A = rnd_mat(); op = 2'($urandom); start = (i == 12);
            tick();
            if (done) dcnt++;
        end
        start = 1'b0;
        for (int i = 0; i < N; i++) expv[i*W +: W] = f(o0, m0[i*W +: W]);
        chk("stable_result", resultado, expv);
        chk("stable_done_count", VW'(dcnt), VW'(1));
        chk("stable_no_rerun", VW'(busy), '0);

        // abort at element 10
        matriz_A = {N{8'h33}}; op = 2'b10; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(10);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        expv = '0;
        for (int i = 0; i < 10; i++) expv[i*W +: W] = 8'h33;
        chk("abort_result", resultado, expv);
        chk("abort_busy", VW'(busy), '0);
        chk("abort_done", VW'(done), '0);
        dcnt = 0;
        for (int i = 0; i < 30; i++) begin tick(); if (done) dcnt++; end
        chk("abort_no_done", VW'(dcnt), '0);

        // reset mid-run, checked between edges
        matriz_A = rnd_mat(); op = 2'b00; start = 1'b1;
        tick();
        start = 1'b0;
        wait_idx(7);
        chk("pre_reset_busy", VW'(busy), VW'(1));
        #2 reset = 1'b0;
        #1;
        chk("async_rst_resultado", resultado, '0);
        chk("async_rst_busy", VW'(busy), '0);
        chk("async_rst_done", VW'(done), '0);
        chk("async_rst_idx", VW'(elem_idx), '0);
        @(posedge clk); #1 reset = 1'b1;
        m0 = rnd_mat();
        run_op(2'b01, m0, lat, bcnt);
        chk("post_reset_latency", VW'(lat), VW'(25));
        tick();

        // random runs with sporadic aborts
        for (int r = 0; r < 6; r++) begin
            matriz_A = rnd_mat(); op = 2'($urandom); start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < 30; i++) begin
                abort = ($urandom_range(15) == 0);
                matriz_A = rnd_mat();
                tick();
            end
            abort = 1'b0;
        end

        // back-to-back with start held; abort high in IDLE must not block starts
        matriz_A = rnd_mat(); op = 2'b00; start = 1'b1; abort = 1'b1;
        tick();
        abort = 1'b0;
        pb = busy; pd = done; dbl = 1'b0;
        if (busy) rise_q.push_back(0);
        for (int s = 1; s < 60; s++) begin
            tick();
            if (busy && !pb) rise_q.push_back(s);
            if (done) done_q.push_back(s);
            if (done && pd) dbl = 1'b1;
            pb = busy; pd = done;
        end
        start = 1'b0;
        chk("b2b_done_count", VW'(done_q.size()), VW'(2));
        chk("b2b_rise_count", VW'(rise_q.size()), VW'(3));
        chk("b2b_done_width", VW'(dbl), '0);
        if (done_q.size() >= 2 && rise_q.size() >= 2) begin
            chk("b2b_period", VW'(done_q[1] - done_q[0]), VW'(27));
            chk("b2b_gap", VW'(rise_q[1] - done_q[0]), VW'(2));
        end
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        chk("b2b_drain", VW'(busy), '0);
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
